// File: rtl/mux8_rr_scheduler_if.sv
// Bundle of request/payload, grant/select and downstream handshake signals
// between the requesters, the mux8_rr_scheduler and the consumer.
// Optional macro FIXED_PRIO_EN adds the prio_mode control bit.
//
// Handshake: out_data is offered while out_valid=1 and is consumed on a rising
// clk edge where out_valid & out_ready. Once offered, sel/out_data/out_valid do
// not change until consumed. Each req[i] is held together with in[i] until the
// cycle in which gnt[i]=1.
interface mux8_rr_scheduler_if;
  logic [7:0] req;
  logic [7:0] in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef FIXED_PRIO_EN
  logic       prio_mode;

  modport master (
    output req, in, out_ready, prio_mode,
    input  gnt, sel, out_data, out_valid, busy
  );

  modport slave (
    input  req, in, out_ready, prio_mode,
    output gnt, sel, out_data, out_valid, busy
  );
`else
  modport master (
    output req, in, out_ready,
    input  gnt, sel, out_data, out_valid, busy
  );

  modport slave (
    input  req, in, out_ready,
    output gnt, sel, out_data, out_valid, busy
  );
`endif
endinterface

// File: rtl/mux8_rr_scheduler.sv
// Round-robin sequencer for a shared 8:1 bit-select datapath. Picks one of 8
// requesters, drives sel to it, captures in[sel] and offers the bit downstream
// through a valid/ready register stage. A winner may keep the datapath for up
// to QUANTUM consecutive transfers before priority rotates past it.
// Optional macro FIXED_PRIO_EN: adds prio_mode; when 1 the rotation winner is
// the lowest-index requester (ptr is still maintained).
module mux8_rr_scheduler #(
  parameter int QUANTUM = 1,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux8_rr_scheduler_if.slave bus,
  output logic             dbg_state,
  output logic [2:0]       dbg_ptr,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  logic             data_q;
  logic             valid_q;

  logic [2:0]       rot_base;
  logic [3:0]       pick;
  logic [CNT_W:0]   cnt_plus;
  logic             cont;
  logic             cap;
  logic [2:0]       winner;
  logic             prio;

  // Circular first-set search starting at base; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    // Walk from the far end so the closest requester to base is written last.
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef FIXED_PRIO_EN
  assign prio = bus.prio_mode;
`else
  assign prio = 1'b0;
`endif

  // In FULL the search starts just past the current owner, i.e. the pointer
  // value that rotation is about to store, so rotation costs no extra cycle.
  assign rot_base = (state == FULL) ? 3'(sel_q + 3'd1) : ptr;
  assign cnt_plus = {1'b0, cnt} + 1'b1;
  assign cont     = (state == FULL) && (cnt_plus < (CNT_W+1)'(QUANTUM)) && bus.req[sel_q];

  // Winner selection and capture decision for this cycle.
  always_comb begin
    cap    = 1'b0;
    winner = 3'd0;
    pick   = prio ? rr_pick(bus.req, 3'd0) : rr_pick(bus.req, rot_base);
    if (state == IDLE) begin
      cap    = pick[3];
      winner = pick[2:0];
    end else if (bus.out_ready) begin
      if (cont) begin
        cap    = 1'b1;
        winner = sel_q;
      end else begin
        cap    = pick[3];
        winner = pick[2:0];
      end
    end
  end

  // Grant strobe is combinational and forced low while reset is held.
  assign bus.gnt = (cap && rst_n) ? (8'b1 << winner) : 8'b0;

  // Single FSM: capture register, output valid, pointer and quantum counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      sel_q   <= 3'd0;
      cnt     <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cap) begin
            sel_q   <= winner;
            data_q  <= bus.in[winner];
            cnt     <= '0;
            valid_q <= 1'b1;
            state   <= FULL;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            if (cont) begin
              cnt <= cnt + 1'b1;
            end else begin
              ptr <= sel_q + 3'd1;
              cnt <= '0;
            end
            if (cap) begin
              sel_q  <= winner;
              data_q <= bus.in[winner];
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = valid_q;

  assign dbg_state = state;
  assign dbg_ptr   = ptr;
  assign dbg_cnt   = cnt;

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
- Shares one 8:1 bit-select datapath between 8 requesters using round-robin arbitration.
- Each requester presents a 1-bit payload on in[i] with req[i]. The block picks a winner, drives sel to that index, and captures in[sel] into an output register.
- The captured bit is offered downstream with a valid/ready handshake.
- Sits in front of the 8:1 mux; it is the sequencer that decides which select value is applied, and when.

Parameters:
- QUANTUM, 1: max consecutive transfers one requester may win before priority rotates (legal 1..15).
- CNT_W, 4: width of the quantum counter; must hold QUANTUM-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request per source; held with in[i] until the matching gnt[i].
- in  input  8  payload bits, in[i] belongs to source i.
- gnt  output  8  one-hot capture strobe, combinational; gnt[i]=1 in the cycle in[i] is captured.
- sel  output  3  registered index of the current/last captured source (the 8:1 select).
- out_data  output  1  registered captured bit.
- out_valid  output  1  out_data holds an unconsumed bit.
- out_ready  input  1  downstream accepts out_data when out_valid & out_ready.
- busy  output  1  equals out_valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: sel=0, out_data=0, out_valid=0, ptr=0, cnt=0, state=IDLE; gnt=0 while rst_n=0.
- Round-robin winner: first i with req[i]=1, searching circularly from ptr (ptr, ptr+1 … 7, 0 … ptr-1).
- ptr: internal 3-bit pointer.
- States: IDLE (out_valid=0) and FULL (out_valid=1).
- Capture condition: cap = (state==IDLE & |req) | (state==FULL & out_ready & |req_eligible).
- On cap, at the clock edge: sel<=winner, out_data<=in[winner], state<=FULL. gnt[winner]=1 combinationally in that cycle.
- Latency: req asserted in IDLE gives out_valid=1 on the next edge, i.e. 1 cycle.
- FULL with out_ready=0: sel, out_data and out_valid hold stable; gnt=0; no arbitration.
- FULL with out_ready=1: the transfer completes. Then:
  - Continuation: if cnt+1 < QUANTUM and req[sel]=1, recapture from sel (cnt<=cnt+1, ptr unchanged).
  - Rotation: otherwise ptr<=sel+1 (7 wraps to 0) and cnt<=0. Arbitrate from the new ptr in the same cycle (the search uses sel+1 combinationally). Capture if any req, else state<=IDLE, out_valid<=0.
- No bubble between back-to-back transfers. Sustained throughput is 1 bit/cycle with out_ready=1.
- A fresh capture from IDLE sets cnt=0.
- req_eligible covers both paths above: req[sel] for continuation, or any req for rotation.
- A requester that drops req mid-wait is simply skipped. A bit already captured is never withdrawn.
- gnt is never asserted for a source whose req=0. gnt is at most one-hot.
- Reset mid-transfer: the pending bit is discarded and all state returns to reset values immediately, without waiting for clk.
- With QUANTUM=1, pure round-robin: no source wins twice while another source is requesting.

Optional Feature:
- Macro: FIXED_PRIO_EN.
- Defined: adds input prio_mode (1 bit). When prio_mode=1, the winner is the lowest-index requesting source, ptr is ignored (still updated as normal), and QUANTUM still applies. When prio_mode=0, behaviour is the round-robin above.
- Not defined: no prio_mode port; round-robin only.

Test Plan:
1. Reset then single request: req=8'h04, in=8'h04, out_ready=1. Expect gnt=8'h04 for 1 cycle, then sel=2, out_data=1, out_valid=1, and ptr becomes 3 after accept.
2. Round-robin fairness: QUANTUM=1, req=8'hFF held, in=8'b01010110, out_ready=1. Expect sel sequence 0,1,2,…,7,0 and out_data 0,1,1,0,1,0,1,0 with no idle cycles.
3. Wrap-around: ptr=7 (after serving 6), req=8'h81. Expect 7 served, then 0, then 7.
4. Backpressure: out_ready=0 for 5 cycles while out_valid=1 and req=8'hFF. Expect sel/out_data stable, gnt=0. The transfer completes on the cycle out_ready rises.
5. Quantum: QUANTUM=3, req=8'h03 held. Expect sel 0,0,0,1,1,1,0…; with req[0] dropped after the first win, expect sel 0,1,1,1.
6. Async reset mid-FULL: assert rst_n=0 between clock edges. Expect out_valid=0, sel=0 and gnt=0 immediately. After release with req=8'h20, the first grant is source 5.
